// File: rtl/bounce_gen_pkg.sv
// Shared types and constants for the contact-bounce emulator.
package bounce_gen_pkg;

  typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} bounce_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11, maximal length
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/bounce_gen_lfsr16.sv
// 16-bit Fibonacci LFSR, advances every cycle; a non-zero seed keeps it off the all-zero lock-up state.
module lfsr16
  import bounce_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] o_q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) o_q <= LFSR_SEED;
    else      o_q <= {o_q[14:0], ^(o_q & LFSR_TAPS)};
  end

endmodule

// File: rtl/bounce_gen.sv
// Contact-bounce emulator: turns a clean level request into a toggle burst plus settle time, counted in i_tick pulses.
// BOUNCE_GEN_LFSR_EN selects pseudo-random segment widths in 1..BOUNCE_TICKS instead of a fixed width.
module bounce_gen
  import bounce_gen_pkg::*;
#(
  parameter int N_BOUNCES    = 2,
  parameter int BOUNCE_TICKS = 4,
  parameter int SETTLE_TICKS = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_level,
  output logic o_signal,
  output logic o_busy,
  output logic o_done
);

  localparam int SEG_W = $clog2(BOUNCE_TICKS + 1);
  localparam int TOG_W = $clog2(2 * N_BOUNCES + 2);
  localparam int SET_W = (SETTLE_TICKS > 0) ? $clog2(SETTLE_TICKS + 1) : 1;
  localparam int TOTAL = 2 * N_BOUNCES + 1;

  if (SETTLE_TICKS < 1) begin : g_bad_settle
    $error("bounce_gen: SETTLE_TICKS must be >= 1");
  end

  bounce_state_t    state, state_nx;
  logic             sig_nx, done_nx, target, target_nx;
  logic [SEG_W-1:0] seg_cnt, seg_nx, seg_width;
  logic [TOG_W-1:0] tog_cnt, tog_nx, tog_inc;
  logic [SET_W-1:0] set_cnt, set_nx;

`ifdef BOUNCE_GEN_LFSR_EN
  localparam int LW = (BOUNCE_TICKS > 1) ? $clog2(BOUNCE_TICKS) : 1;
  logic [15:0] lfsr_q;
  logic        lfsr_unused;

  lfsr16 u_lfsr (
    .clk (clk),
    .rst (rst),
    .o_q (lfsr_q)
  );

  assign seg_width   = SEG_W'(1) + SEG_W'(lfsr_q[LW-1:0] & LW'(BOUNCE_TICKS - 1));
  assign lfsr_unused = ^lfsr_q[15:LW];
`else
  assign seg_width = SEG_W'(BOUNCE_TICKS);
`endif

  always_comb begin
    state_nx  = state;
    sig_nx    = o_signal;
    target_nx = target;
    seg_nx    = seg_cnt;
    tog_nx    = tog_cnt;
    set_nx    = set_cnt;
    done_nx   = 1'b0;
    tog_inc   = tog_cnt + TOG_W'(1);
    case (state)
      IDLE: begin
        // Ticks on the starting edge are ignored: this edge only loads counters.
        if (i_level != o_signal) begin
          target_nx = i_level;
          sig_nx    = ~o_signal;
          tog_nx    = TOG_W'(1);
          seg_nx    = seg_width;
          if (TOTAL == 1) begin
            set_nx   = SET_W'(SETTLE_TICKS);
            state_nx = SETTLE;
          end else begin
            state_nx = BOUNCE;
          end
        end
      end
      BOUNCE: begin
        if (i_tick) begin
          if (seg_cnt == SEG_W'(1)) begin
            tog_nx = tog_inc;
            if (tog_inc == TOG_W'(TOTAL)) begin
              // Odd toggle count lands on the target; drive it explicitly.
              sig_nx   = target;
              set_nx   = SET_W'(SETTLE_TICKS);
              state_nx = SETTLE;
            end else begin
              sig_nx = ~o_signal;
              seg_nx = seg_width;
            end
          end else begin
            seg_nx = seg_cnt - SEG_W'(1);
          end
        end
      end
      SETTLE: begin
        if (i_tick) begin
          if (set_cnt == SET_W'(1)) begin
            done_nx  = 1'b1;
            state_nx = IDLE;
          end else begin
            set_nx = set_cnt - SET_W'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      o_signal <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      target   <= 1'b0;
      seg_cnt  <= '0;
      tog_cnt  <= '0;
      set_cnt  <= '0;
    end else begin
      state    <= state_nx;
      o_signal <= sig_nx;
      o_busy   <= (state_nx != IDLE);
      o_done   <= done_nx;
      target   <= target_nx;
      seg_cnt  <= seg_nx;
      tog_cnt  <= tog_nx;
      set_cnt  <= set_nx;
    end
  end

endmodule

// File: tb/tb_bounce_gen.sv
// Bench for bounce_gen: observes bursts in tick units and compares against the toggle/segment/settle rules.
module tb_bounce_gen;

  localparam int NB = 2;
  localparam int BT = 4;
  localparam int ST = 3;

  logic clk, rst, i_tick, lvl_a, lvl_b;
  logic sig_a, busy_a, done_a, sig_b, busy_b, done_b;
  int   total, bad, tick_ph;
  int   seg_q[$];
  int   wseen[BT+1];

  bounce_gen #(.N_BOUNCES(NB), .BOUNCE_TICKS(BT), .SETTLE_TICKS(ST)) dut_a (
    .clk(clk), .rst(rst), .i_tick(i_tick), .i_level(lvl_a),
    .o_signal(sig_a), .o_busy(busy_a), .o_done(done_a)
  );

  bounce_gen #(.N_BOUNCES(0), .BOUNCE_TICKS(BT), .SETTLE_TICKS(1)) dut_b (
    .clk(clk), .rst(rst), .i_tick(i_tick), .i_level(lvl_b),
    .o_signal(sig_b), .o_busy(busy_b), .o_done(done_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Tick strobe every 10 clocks, changed only on falling edges.
  initial begin
    i_tick  = 1'b0;
    tick_ph = 0;
    forever begin
      @(negedge clk);
      tick_ph = (tick_ph == 9) ? 0 : tick_ph + 1;
      i_tick  = (tick_ph == 9);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_seg(input string name, input int w);
    total++;
    if (w >= 0 && w <= BT) wseen[w]++;
`ifdef BOUNCE_GEN_LFSR_EN
    if (w < 1 || w > BT) begin
      bad++;
      $display("FAIL %s segment width: got %0d, expected 1..%0d", name, w, BT);
    end
`else
    if (w != BT) begin
      bad++;
      $display("FAIL %s segment width: got %0d, expected %0d", name, w, BT);
    end
`endif
  endtask

  // Watches one burst; ticks after a toggle are attributed to the segment (or settle) that follows it.
  task automatic collect(input bit sel, input logic start_sig, input int revert_at,
                         output int n_tog, output int first_cyc, output int settle,
                         output int n_done, output int busy_drop, output logic fin);
    logic prev, s, b, d, t;
    int   ticks;
    prev = start_sig; ticks = 0; n_tog = 0; first_cyc = -1; settle = -1;
    n_done = 0; busy_drop = 0;
    seg_q.delete();
    for (int cyc = 1; cyc <= 3000 && n_done == 0; cyc++) begin
      @(posedge clk); #1;
      t = i_tick;
      s = sel ? sig_b : sig_a;
      b = sel ? busy_b : busy_a;
      d = sel ? done_b : done_a;
      if (revert_at == cyc) begin
        if (sel) lvl_b = ~lvl_b; else lvl_a = ~lvl_a;
      end
      if (n_tog > 0 && t) ticks++;
      if (s != prev) begin
        if (n_tog > 0) seg_q.push_back(ticks);
        ticks = 0;
        n_tog++;
        if (first_cyc < 0) first_cyc = cyc;
      end
      if (d) begin
        n_done++;
        settle = ticks;
      end else if (n_tog > 0 && !b) begin
        busy_drop++;
      end
      prev = s;
    end
    fin = prev;
  endtask

  task automatic burst(input string nm, input bit sel, input logic start_sig, input int revert_at,
                       input int exp_tog, input int exp_set, input logic exp_fin);
    int   n_tog, first_cyc, settle, n_done, busy_drop;
    logic fin;
    collect(sel, start_sig, revert_at, n_tog, first_cyc, settle, n_done, busy_drop, fin);
    check({nm, " first toggle cycle"}, first_cyc, 1);
    check({nm, " toggles"}, n_tog, exp_tog);
    check({nm, " segments"}, seg_q.size(), exp_tog - 1);
    foreach (seg_q[i]) check_seg(nm, seg_q[i]);
    check({nm, " settle ticks"}, settle, exp_set);
    check({nm, " done pulses"}, n_done, 1);
    check({nm, " final level"}, int'(fin), int'(exp_fin));
    check({nm, " busy gaps"}, busy_drop, 0);
  endtask

  task automatic quiet(input bit sel, input int n, output int dn, output int tg, output int bz);
    logic prev;
    prev = sel ? sig_b : sig_a;
    dn = 0; tg = 0; bz = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (sel ? done_b : done_a) dn++;
      if (sel ? busy_b : busy_a) bz++;
      if ((sel ? sig_b : sig_a) != prev) tg++;
      prev = sel ? sig_b : sig_a;
    end
  endtask

  typedef struct {
    logic lvl;
    int   gap;
    int   exp_tog;
    logic exp_fin;
  } vec_t;

  initial begin
    vec_t vecs[4];
    int   dn, tg, bz, tog_seen, distinct;
    logic cur;

    total = 0; bad = 0;
    foreach (wseen[i]) wseen[i] = 0;
    rst = 1'b0; lvl_a = 1'b0; lvl_b = 1'b0;

    vecs[0] = '{lvl: 1'b1, gap: 3,  exp_tog: 2*NB+1, exp_fin: 1'b1};
    vecs[1] = '{lvl: 1'b0, gap: 0,  exp_tog: 2*NB+1, exp_fin: 1'b0};
    vecs[2] = '{lvl: 1'b1, gap: 7,  exp_tog: 2*NB+1, exp_fin: 1'b1};
    vecs[3] = '{lvl: 1'b0, gap: 12, exp_tog: 2*NB+1, exp_fin: 1'b0};

    #1;
    check("reset o_signal", int'(sig_a), 0);
    check("reset o_busy", int'(busy_a), 0);
    check("reset o_done", int'(done_a), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    quiet(0, 5, dn, tg, bz);
    check("idle toggles", tg, 0);
    check("idle busy", bz, 0);

    // Clean transitions from the table, each followed by a quiet window.
    for (int i = 0; i < 4; i++) begin
      repeat (vecs[i].gap + 1) @(negedge clk);
      lvl_a = vecs[i].lvl;
      burst($sformatf("vec%0d", i), 0, ~vecs[i].lvl, 0, vecs[i].exp_tog, ST, vecs[i].exp_fin);
      quiet(0, 15, dn, tg, bz);
      check($sformatf("vec%0d extra done", i), dn, 0);
      check($sformatf("vec%0d extra toggles", i), tg, 0);
    end

    // Request reverted mid-burst: burst completes, then a new one starts right away.
    @(negedge clk);
    lvl_a = 1'b1;
    burst("revert first", 0, 1'b0, 60, 2*NB+1, ST, 1'b1);
    burst("revert second", 0, 1'b1, 0, 2*NB+1, ST, 1'b0);

    // Reset at the third toggle aborts the burst silently.
    @(negedge clk);
    lvl_a = 1'b1;
    begin
      logic prev;
      prev = 1'b0; tog_seen = 0;
      for (int c = 0; c < 1000 && tog_seen < 3; c++) begin
        @(posedge clk); #1;
        if (sig_a != prev) tog_seen++;
        prev = sig_a;
      end
    end
    check("reset wait toggles", tog_seen, 3);
    #2 rst = 1'b0;
    #1;
    check("abort o_signal", int'(sig_a), 0);
    check("abort o_busy", int'(busy_a), 0);
    quiet(0, 4, dn, tg, bz);
    check("abort done", dn, 0);
    @(negedge clk);
    rst = 1'b1;
    burst("after reset", 0, 1'b0, 0, 2*NB+1, ST, 1'b1);

    // Zero-bounce instance: single toggle, done one tick later.
    @(negedge clk);
    lvl_b = 1'b1;
    burst("nb0 rise", 1, 1'b0, 0, 1, 1, 1'b1);
    @(negedge clk);
    lvl_b = 1'b0;
    burst("nb0 fall", 1, 1'b1, 0, 1, 1, 1'b0);

    // Randomized requests; about one in four repeats the current level and must do nothing.
    foreach (wseen[i]) wseen[i] = 0;
    cur = 1'b1;
    for (int k = 0; k < 200; k++) begin
      repeat ($urandom_range(0, 12) + 1) @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        lvl_a = cur;
        quiet(0, 12, dn, tg, bz);
        check($sformatf("rnd%0d hold toggles", k), tg, 0);
        check($sformatf("rnd%0d hold busy", k), bz, 0);
      end else begin
        lvl_a = ~cur;
        burst($sformatf("rnd%0d", k), 0, cur, 0, 2*NB+1, ST, ~cur);
        cur = ~cur;
      end
    end
    distinct = 0;
    for (int w = 1; w <= BT; w++) if (wseen[w] > 0) distinct++;
`ifdef BOUNCE_GEN_LFSR_EN
    check("width variety", int'(distinct > 1), 1);
`else
    check("width variety", distinct, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
